// File: rtl/mm_pkg.sv
// Shared types and helpers for the memory-mapped one-to-many decoder.
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  // Slave index taken from the address bits above the slave window.
  function automatic int slave_index(input logic [31:0] addr, input int awidth, input int swidth);
    logic [31:0] mask;
    mask = (32'd1 << (awidth - swidth)) - 32'd1;
    return int'((addr >> swidth) & mask);
  endfunction

  function automatic int counter_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mm_decoder_if.sv
// Master-side bus plus the per-slave fan-out bus of the decoder.
interface mm_decoder_if #(
  parameter int AWIDTH = 8,
  parameter int SWIDTH = 6,
  parameter int DWIDTH = 8,
  parameter int SLAVES = 3
);

  logic [AWIDTH-1:0]              s_addr;
  logic                           s_wreq;
  logic [DWIDTH-1:0]              s_wdat;
  logic                           s_rreq;
  logic [DWIDTH-1:0]              s_rdat;
  logic                           s_rdyn;
  logic [SLAVES-1:0][SWIDTH-1:0]  m_addr;
  logic [SLAVES-1:0]              m_wreq;
  logic [SLAVES-1:0][DWIDTH-1:0]  m_wdat;
  logic [SLAVES-1:0]              m_rreq;
  logic [SLAVES-1:0][DWIDTH-1:0]  m_rdat;
  logic [SLAVES-1:0]              m_rdyn;

  // The decoder itself takes the slave view of the upstream bus.
  modport slave (
    input  s_addr, s_wreq, s_wdat, s_rreq, m_rdat, m_rdyn,
    output s_rdat, s_rdyn, m_addr, m_wreq, m_wdat, m_rreq
  );

  modport master (
    output s_addr, s_wreq, s_wdat, s_rreq, m_rdat, m_rdyn,
    input  s_rdat, s_rdyn, m_addr, m_wreq, m_wdat, m_rreq
  );

endinterface

// File: rtl/mm_decoder.sv
// Registered one-to-many memory-mapped decoder with unmapped-address and
// hung-slave protection so the master always receives a completion.
module mm_decoder
  import mm_pkg::*;
#(
  parameter int               AWIDTH  = 8,
  parameter int               SWIDTH  = 6,
  parameter int               DWIDTH  = 8,
  parameter int               SLAVES  = 3,
  parameter int               TIMEOUT = 16,
  parameter logic [DWIDTH-1:0] ERRDATA = '0
) (
  input  logic       clk,
  input  logic       reset,
  mm_decoder_if.slave bus,
  output logic       err_unmap,
  output logic       err_tout
);

  localparam int CWIDTH = counter_width(TIMEOUT);

  state_t              state_q, state_d;
  logic [SWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   wdat_q, wdat_d;
  logic                write_q, write_d;
  logic [SLAVES-1:0]   sel_q, sel_d;
  logic [CWIDTH-1:0]   cnt_q, cnt_d;
  logic [DWIDTH-1:0]   rdat_q, rdat_d;
  logic                errUnmap_q, errUnmap_d;
  logic                errTout_q, errTout_d;
  logic [DWIDTH-1:0]   selRdat;
  logic                selReady;
  int                  reqIdx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdat_q     <= '0;
      write_q    <= 1'b0;
      sel_q      <= '0;
      cnt_q      <= '0;
      rdat_q     <= '0;
      errUnmap_q <= 1'b0;
      errTout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      write_q    <= write_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      rdat_q     <= rdat_d;
      errUnmap_q <= errUnmap_d;
      errTout_q  <= errTout_d;
    end
  end

  // The one-hot select keeps non-selected slaves' rdyn/rdat out of the result.
  always_comb begin
    selRdat  = '0;
    selReady = 1'b0;
    for (int i = 0; i < SLAVES; i++) begin
      if (sel_q[i]) begin
        selRdat  |= bus.m_rdat[i];
        selReady |= ~bus.m_rdyn[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    write_d    = write_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    rdat_d     = rdat_q;
    errUnmap_d = 1'b0;
    errTout_d  = 1'b0;
    reqIdx     = slave_index(32'(bus.s_addr), AWIDTH, SWIDTH);

    case (state_q)
      IDLE: begin
        if (bus.s_wreq || bus.s_rreq) begin
          addr_d  = bus.s_addr[SWIDTH-1:0];
          wdat_d  = bus.s_wdat;
          write_d = bus.s_wreq;
          for (int i = 0; i < SLAVES; i++) begin
            sel_d[i] = (reqIdx == i);
          end
          if (reqIdx < SLAVES) begin
            state_d = ACCESS;
            cnt_d   = '0;
          end else begin
            state_d    = DONE;
            errUnmap_d = 1'b1;
            if (!bus.s_wreq) rdat_d = ERRDATA;
          end
        end
      end
      ACCESS: begin
        // A completion on the limit cycle beats the watchdog.
        if (selReady) begin
          if (!write_q) rdat_d = selRdat;
          state_d = DONE;
        end else if (TIMEOUT > 0 && cnt_q == CWIDTH'(TIMEOUT - 1)) begin
          if (!write_q) rdat_d = ERRDATA;
          errTout_d = 1'b1;
          state_d   = DONE;
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt_q + CWIDTH'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.m_wreq = (state_q == ACCESS &&  write_q) ? sel_q : '0;
  assign bus.m_rreq = (state_q == ACCESS && !write_q) ? sel_q : '0;
  assign bus.m_addr = {SLAVES{addr_q}};
  assign bus.m_wdat = {SLAVES{wdat_q}};
  assign bus.s_rdyn = (state_q != DONE);
  assign bus.s_rdat = rdat_q;
  assign err_unmap  = errUnmap_q;
  assign err_tout   = errTout_q;

endmodule

// File: tb/tb_mm_decoder.sv
// Directed self-checking bench for mm_decoder with TIMEOUT=4, ERRDATA=8'hEE.
module tb_mm_decoder;

  logic clk;
  logic reset;
  logic err_unmap;
  logic err_tout;
  int   assertCount;
  int   failCount;

  mm_decoder_if #(.AWIDTH(8), .SWIDTH(6), .DWIDTH(8), .SLAVES(3)) bus ();

  mm_decoder #(
    .AWIDTH(8), .SWIDTH(6), .DWIDTH(8), .SLAVES(3), .TIMEOUT(4), .ERRDATA(8'hEE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .err_unmap(err_unmap),
    .err_tout(err_tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input logic wreq, input logic rreq, input logic [7:0] wdat);
    bus.s_addr = addr;
    bus.s_wreq = wreq;
    bus.s_rreq = rreq;
    bus.s_wdat = wdat;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    bus.m_rdyn = 3'b111;
    bus.m_rdat = '0;

    #3;
    checkOutput("reset s_rdyn", 32'(bus.s_rdyn), 32'h1);
    checkOutput("reset s_rdat", 32'(bus.s_rdat), 32'h0);
    checkOutput("reset m_wreq", 32'(bus.m_wreq), 32'h0);
    checkOutput("reset m_rreq", 32'(bus.m_rreq), 32'h0);
    checkOutput("reset m_addr", 32'(bus.m_addr), 32'h0);
    checkOutput("reset m_wdat", 32'(bus.m_wdat), 32'h0);
    checkOutput("reset errs", {30'b0, err_unmap, err_tout}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset released");

    // Write 0x45 <- A5, slave1 zero-wait
    bus.m_rdyn = 3'b101;
    applyStimulus(8'h45, 1'b1, 1'b0, 8'hA5);
    checkOutput("wr c0 s_rdyn", 32'(bus.s_rdyn), 32'h1);
    nextCycle();
    checkOutput("wr c1 m_wreq", 32'(bus.m_wreq), 32'h2);
    checkOutput("wr c1 m_rreq", 32'(bus.m_rreq), 32'h0);
    checkOutput("wr c1 m_addr", 32'(bus.m_addr[1]), 32'h05);
    checkOutput("wr c1 m_wdat", 32'(bus.m_wdat[1]), 32'hA5);
    checkOutput("wr c1 s_rdyn", 32'(bus.s_rdyn), 32'h1);
    nextCycle();
    checkOutput("wr c2 s_rdyn", 32'(bus.s_rdyn), 32'h0);
    checkOutput("wr c2 m_wreq", 32'(bus.m_wreq), 32'h0);
    checkOutput("wr c2 errs", {30'b0, err_unmap, err_tout}, 32'h0);
    checkOutput("wr c2 s_rdat", 32'(bus.s_rdat), 32'h0);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    bus.m_rdyn = 3'b111;
    nextCycle();
    checkOutput("wr c3 s_rdyn", 32'(bus.s_rdyn), 32'h1);

    // Read 0x83 from slave2 with two wait cycles
    bus.m_rdat[2] = 8'h77;
    applyStimulus(8'h83, 1'b0, 1'b1, 8'h00);
    for (int c = 1; c <= 3; c++) begin
      nextCycle();
      checkOutput($sformatf("rd2 c%0d m_rreq", c), 32'(bus.m_rreq), 32'h4);
      checkOutput($sformatf("rd2 c%0d s_rdyn", c), 32'(bus.s_rdyn), 32'h1);
    end
    checkOutput("rd2 m_addr", 32'(bus.m_addr[2]), 32'h03);
    bus.m_rdyn[2] = 1'b0;
    bus.m_rdat[2] = 8'h3C;
    nextCycle();
    checkOutput("rd2 c4 s_rdyn", 32'(bus.s_rdyn), 32'h0);
    checkOutput("rd2 c4 s_rdat", 32'(bus.s_rdat), 32'h3C);
    checkOutput("rd2 c4 m_rreq", 32'(bus.m_rreq), 32'h0);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    bus.m_rdyn[2] = 1'b1;
    bus.m_rdat[2] = 8'h55;
    nextCycle();
    checkOutput("rd2 c5 s_rdat hold", 32'(bus.s_rdat), 32'h3C);
    checkOutput("rd2 c5 s_rdyn", 32'(bus.s_rdyn), 32'h1);

    // Unmapped read 0xC0
    bus.m_rdyn = 3'b000;
    applyStimulus(8'hC0, 1'b0, 1'b1, 8'h00);
    nextCycle();
    checkOutput("unmap c1 s_rdyn", 32'(bus.s_rdyn), 32'h0);
    checkOutput("unmap c1 s_rdat", 32'(bus.s_rdat), 32'hEE);
    checkOutput("unmap c1 err_unmap", 32'(err_unmap), 32'h1);
    checkOutput("unmap c1 reqs", {26'b0, bus.m_wreq, bus.m_rreq}, 32'h0);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    bus.m_rdyn = 3'b111;
    nextCycle();
    checkOutput("unmap c2 err_unmap", 32'(err_unmap), 32'h0);
    checkOutput("unmap c2 reqs", {26'b0, bus.m_wreq, bus.m_rreq}, 32'h0);
    checkOutput("unmap c2 s_rdyn", 32'(bus.s_rdyn), 32'h1);

    // Read 0x10, slave0 answers exactly on the limit cycle
    applyStimulus(8'h10, 1'b0, 1'b1, 8'h00);
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      checkOutput($sformatf("lim c%0d m_rreq", c), 32'(bus.m_rreq), 32'h1);
    end
    bus.m_rdyn[0] = 1'b0;
    bus.m_rdat[0] = 8'h5A;
    nextCycle();
    checkOutput("lim c5 s_rdyn", 32'(bus.s_rdyn), 32'h0);
    checkOutput("lim c5 s_rdat", 32'(bus.s_rdat), 32'h5A);
    checkOutput("lim c5 err_tout", 32'(err_tout), 32'h0);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    bus.m_rdyn = 3'b111;
    nextCycle();

    // Read 0x10, slave0 hung -> timeout
    applyStimulus(8'h10, 1'b0, 1'b1, 8'h00);
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      checkOutput($sformatf("tout c%0d m_rreq", c), 32'(bus.m_rreq), 32'h1);
      checkOutput($sformatf("tout c%0d s_rdyn", c), 32'(bus.s_rdyn), 32'h1);
      checkOutput($sformatf("tout c%0d err_tout", c), 32'(err_tout), 32'h0);
    end
    nextCycle();
    checkOutput("tout c5 m_rreq", 32'(bus.m_rreq), 32'h0);
    checkOutput("tout c5 s_rdyn", 32'(bus.s_rdyn), 32'h0);
    checkOutput("tout c5 s_rdat", 32'(bus.s_rdat), 32'hEE);
    checkOutput("tout c5 err_tout", 32'(err_tout), 32'h1);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    nextCycle();
    checkOutput("tout c6 err_tout", 32'(err_tout), 32'h0);

    // Simultaneous write and read to 0x41: write wins
    bus.m_rdyn = 3'b101;
    bus.m_rdat[1] = 8'h12;
    applyStimulus(8'h41, 1'b1, 1'b1, 8'h99);
    nextCycle();
    checkOutput("both c1 m_wreq", 32'(bus.m_wreq), 32'h2);
    checkOutput("both c1 m_rreq", 32'(bus.m_rreq), 32'h0);
    checkOutput("both c1 m_wdat", 32'(bus.m_wdat[1]), 32'h99);
    nextCycle();
    checkOutput("both c2 s_rdyn", 32'(bus.s_rdyn), 32'h0);
    checkOutput("both c2 s_rdat", 32'(bus.s_rdat), 32'hEE);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    bus.m_rdyn = 3'b111;
    nextCycle();

    // Asynchronous reset in the middle of an access
    applyStimulus(8'h83, 1'b0, 1'b1, 8'h00);
    nextCycle();
    checkOutput("arst c1 m_rreq", 32'(bus.m_rreq), 32'h4);
    nextCycle();
    checkOutput("arst c2 m_rreq", 32'(bus.m_rreq), 32'h4);
    reset = 1'b1;
    #1;
    checkOutput("arst m_rreq", 32'(bus.m_rreq), 32'h0);
    checkOutput("arst s_rdyn", 32'(bus.s_rdyn), 32'h1);
    checkOutput("arst s_rdat", 32'(bus.s_rdat), 32'h0);
    checkOutput("arst m_addr", 32'(bus.m_addr), 32'h0);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    nextCycle();
    reset = 1'b0;

    // Fresh read after reset: 0x45 from slave1, zero-wait
    bus.m_rdyn = 3'b101;
    bus.m_rdat[1] = 8'h6B;
    applyStimulus(8'h45, 1'b0, 1'b1, 8'h00);
    nextCycle();
    checkOutput("post c1 m_rreq", 32'(bus.m_rreq), 32'h2);
    nextCycle();
    checkOutput("post c2 s_rdyn", 32'(bus.s_rdyn), 32'h0);
    checkOutput("post c2 s_rdat", 32'(bus.s_rdat), 32'h6B);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
    nextCycle();
    checkOutput("post c3 s_rdyn", 32'(bus.s_rdyn), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
